// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Bytes are queued in a small FIFO through a valid/ready handshake. Each byte
// is then sent on Tx as one start bit (0), DATA_WIDTH data bits LSB first and
// one stop bit (1). Every bit lasts BAUD_RATE clk cycles. The line idles high.
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   tx_data     byte to queue; tx_valid marks it valid this cycle
//   tx_ready    FIFO can accept (not full), taken from the registered count
//   Tx          registered serial output
//   tx_busy     a frame is in progress
//   tx_done     one-cycle pulse when a frame completes
//   fifo_count  entries waiting in the FIFO (excludes the byte being shifted)
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 1667,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          Tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [31:0]           baud_cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  push, pop, shift, baud_end, tx_n, done_n;

  assign tx_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign baud_end   = (baud_cnt == 32'(BAUD_RATE - 1));
  assign tx_busy    = (state != IDLE);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and line value. The shifter always presents the next data bit
  // at shreg[0]; it shifts right each time a bit is put on the line.
  always_comb begin
    state_n = state;
    tx_n    = Tx;
    done_n  = 1'b0;
    pop     = 1'b0;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          tx_n    = shreg[0];
          shift   = 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_idx == BW'(DATA_WIDTH - 1)) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n  = shreg[0];
            shift = 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          done_n = 1'b1;
          // Chain straight into the next frame so there is no idle gap.
          if (count != '0) begin
            pop     = 1'b1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Tx       <= 1'b1;
      tx_done  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      Tx      <= tx_n;
      tx_done <= done_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shreg  <= mem[rd_ptr];
      end else if (shift) begin
        shreg  <= shreg >> 1;
      end
      count <= count + CW'(push) - CW'(pop);
      // Bit timer restarts at every bit boundary and stays cleared while idle.
      baud_cnt <= (state == IDLE || baud_end) ? '0 : baud_cnt + 32'd1;
      if (state == START)                bit_idx <= '0;
      else if (state == DATA && baud_end) bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (BAUD_RATE=4, FIFO_DEPTH=4). A queue-based
// model predicts every output each cycle; directed scenarios add literal
// expectations and a simple serial decoder recovers the transmitted bytes.
module tb_uart_tx_fifo;
  localparam int DW = 8, B = 4, D = 4, FL = (DW + 2) * B;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, Tx, tx_busy, tx_done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .BAUD_RATE(B), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .Tx(Tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: queue of waiting bytes plus the position inside the current frame.
  logic [7:0] q[$];
  logic [7:0] m_cur;
  bit         m_act = 0, m_done = 0, m_on = 0, m_take;
  int         m_t = 0, m_pre;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_act = 0; m_t = 0; m_done = 0; m_on = 1;
    end else begin
      m_pre  = q.size();
      m_take = 0;
      m_done = 0;
      if (m_act) begin
        if (m_t == FL - 1) begin
          m_done = 1;
          if (m_pre > 0) m_take = 1; else m_act = 0;
        end else m_t++;
      end else if (m_pre > 0) m_take = 1;
      if (m_take) begin m_cur = q.pop_front(); m_act = 1; m_t = 0; end
      if (tx_valid && m_pre < D) q.push_back(tx_data);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_t / B;
    if (k == 0) return 1'b0;
    if (k <= DW) return m_cur[k-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_tx", Tx, exp_tx());
      chk("model_busy", tx_busy, m_act);
      chk("model_done", tx_done, m_done);
      chk("model_count", fifo_count, q.size());
      chk("model_ready", tx_ready, q.size() < D);
    end
  end

  // Serial decoder: samples mid-bit after each falling start edge.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  logic       rx_prev = 1'b0;
  bit         rx_act = 0;
  int         rx_cnt = 0;

  always @(negedge clk) begin
    if (rst) rx_act = 0;
    else if (!rx_act) begin
      if (rx_prev === 1'b1 && Tx === 1'b0) begin rx_act = 1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt % B == B / 2 && rx_cnt / B >= 1 && rx_cnt / B <= DW)
        rx_byte[rx_cnt / B - 1] = Tx;
      if (rx_cnt == B * (DW + 1) + B / 2) begin rx_q.push_back(rx_byte); rx_act = 0; end
    end
    rx_prev = Tx;
  end

  task automatic wait_idle();
    int g = 0;
    while ((tx_busy || fifo_count != 0) && g < 600) begin @(negedge clk); g++; end
    chk("idle_reached", g < 600, 1);
    repeat (3) @(negedge clk);
  endtask

  logic [9:0] frame;
  int         ndone, d, guard, log_n, base, rh;
  bit         acc;
  logic [2:0] cnt_log [5];
  logic [2:0] cnt_exp [5];

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t1_tx", Tx, 1); chk("t1_ready", tx_ready, 1);
      chk("t1_busy", tx_busy, 0); chk("t1_count", fifo_count, 0);
    end

    // Single byte 0xA5
    frame = 10'b1_10100101_0;
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_valid = 1'b0;
    chk("t2_pre_fall", Tx, 1); chk("t2_count", fifo_count, 1);
    ndone = 0;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (j < 40) chk("t2_tx", Tx, frame[j / B]);
      if (tx_done) begin ndone++; chk("t2_done_at", j, 40); end
    end
    chk("t2_done_count", ndone, 1);
    chk("t2_rx", rx_q[$], 8'hA5);
    wait_idle();

    // Hold valid with 0x01..0x06
    cnt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    base = rx_q.size(); d = 1; acc = 0; guard = 0; log_n = 0;
    while (d <= 6 && guard < 300) begin
      @(negedge clk); guard++;
      if (acc) begin
        if (log_n < 5) begin cnt_log[log_n] = fifo_count; log_n++; end
        if (d == 5) chk("t3_full_ready", tx_ready, 0);
        d++;
      end
      if (d <= 6) begin tx_valid = 1'b1; tx_data = 8'(d); acc = tx_ready; end
      else begin tx_valid = 1'b0; acc = 0; end
    end
    tx_valid = 1'b0;
    chk("t3_all_accepted", d, 7);
    for (int i = 0; i < 5; i++) chk("t3_count_seq", cnt_log[i], cnt_exp[i]);
    wait_idle();
    chk("t3_rx_num", rx_q.size(), base + 6);
    for (int i = 0; i < 6; i++) chk("t3_rx_byte", rx_q[base + i], i + 1);

    // 0x00 then 0xFF back to back
    base = rx_q.size();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge clk); tx_data = 8'hFF;
    @(negedge clk); tx_valid = 1'b0;
    chk("t4_tx0", Tx, 0);
    for (int j = 0; j <= 80; j++) begin
      chk("t4_busy", tx_busy, j < 80);
      chk("t4_done", tx_done, j == 40 || j == 80);
      @(negedge clk);
    end
    chk("t4_rx0", rx_q[base], 8'h00);
    chk("t4_rx1", rx_q[base + 1], 8'hFF);
    wait_idle();

    // Reset during data bit 3 with two bytes queued
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h11;
    @(negedge clk); tx_data = 8'h22;
    @(negedge clk); tx_data = 8'h33;
    @(negedge clk); tx_valid = 1'b0;
    chk("t5_queued", fifo_count, 2);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx", Tx, 1); chk("t5_count", fifo_count, 0);
    chk("t5_busy", tx_busy, 0); chk("t5_done", tx_done, 0);
    @(negedge clk); rst = 1'b0;
    base = rx_q.size(); ndone = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (tx_done) ndone++; end
    chk("t5_no_done", ndone, 0);
    tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk); tx_valid = 1'b0;
    wait_idle();
    chk("t5_rx_num", rx_q.size(), base + 1);
    chk("t5_rx", rx_q[$], 8'h3C);

    // Push on the STOP exit pop edge with two queued
    base = rx_q.size();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h44;
    @(negedge clk); tx_data = 8'h55;
    @(negedge clk); tx_data = 8'h66;
    @(negedge clk); tx_valid = 1'b0;
    chk("t6_queued", fifo_count, 2);
    repeat (38) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h77;
    @(negedge clk); tx_valid = 1'b0;
    chk("t6_count", fifo_count, 2); chk("t6_done", tx_done, 1);
    chk("t6_tx", Tx, 0); chk("t6_busy", tx_busy, 1);
    wait_idle();
    chk("t6_rx_num", rx_q.size(), base + 4);
    for (int i = 0; i < 4; i++) chk("t6_rx", rx_q[base + i], 8'h44 + 8'h11 * i);

    // Random traffic with occasional resets
    rh = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tx_valid = ($urandom % 3) != 0;
      tx_data  = 8'($urandom);
      if (rh > 0) begin rh--; rst = 1'b1; end
      else if ($urandom_range(0, 599) == 0) begin rh = 1; rst = 1'b1; end
      else rst = 1'b0;
    end
    rst = 1'b0; tx_valid = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
